// File: rtl/sine_period_peak_detector.sv
// rtl/sine_period_peak_detector.sv - hysteretic zero-crossing period and peak measurement for a signed sinusoid
module sine_period_peak_detector #(
    parameter int WIDTH   = 14,
    parameter int HYST    = 128,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 65536
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample,
    output logic [CNT_W-1:0]        period,
    output logic signed [WIDTH-1:0] peak_max,
    output logic signed [WIDTH-1:0] peak_min,
    output logic [WIDTH:0]          peak_to_peak,
    output logic                    meas_valid,
    output logic                    lost
);

    localparam logic [1:0] ST_ACQ  = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic signed [WIDTH-1:0] HYST_P    = WIDTH'(HYST);
    localparam logic signed [WIDTH-1:0] HYST_N    = -HYST_P;
    localparam logic [CNT_W:0]          TIMEOUT_C = (CNT_W+1)'(TIMEOUT);

    logic [1:0]              state;
    logic                    armed;
    logic [CNT_W-1:0]        cnt;
    logic signed [WIDTH-1:0] run_max;
    logic signed [WIDTH-1:0] run_min;

    logic                    above;
    logic                    below;
    logic                    rising;
    logic                    timeout_hit;
    logic [CNT_W:0]          cnt_inc;
    logic signed [WIDTH-1:0] new_max;
    logic signed [WIDTH-1:0] new_min;
    logic [WIDTH:0]          p2p;

    assign above       = sample >= HYST_P;
    assign below       = sample <= HYST_N;
    assign rising      = (state == ST_LOW) && above;
    assign cnt_inc     = {1'b0, cnt} + (CNT_W+1)'(1);
    assign timeout_hit = cnt_inc == TIMEOUT_C;
    assign new_max     = (sample > run_max) ? sample : run_max;
    assign new_min     = (sample < run_min) ? sample : run_min;
    // Sign-extend one bit so the difference of two extreme samples cannot wrap.
    assign p2p         = {new_max[WIDTH-1], new_max} - {new_min[WIDTH-1], new_min};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ACQ;
            armed        <= 1'b0;
            cnt          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            period       <= '0;
            peak_max     <= '0;
            peak_min     <= '0;
            peak_to_peak <= '0;
            meas_valid   <= 1'b0;
            lost         <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (sample_valid) begin
                if (rising) begin
                    if (armed) begin
                        period       <= cnt_inc[CNT_W-1:0];
                        peak_max     <= new_max;
                        peak_min     <= new_min;
                        peak_to_peak <= p2p;
                        meas_valid   <= 1'b1;
                        lost         <= 1'b0;
                    end
                    run_max <= sample;
                    run_min <= sample;
                    armed   <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_HIGH;
                end else begin
                    run_max <= new_max;
                    run_min <= new_min;
                    if (timeout_hit) begin
                        cnt   <= '0;
                        state <= ST_ACQ;
                        armed <= 1'b0;
                        lost  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                        if (above)
                            state <= ST_HIGH;
                        else if (below)
                            state <= ST_LOW;
                    end
                end
            end
        end
    end

endmodule
